regfile_sb: RTL
===============

# regfile_sb

Parametrised integer register file with a per-register pending-write scoreboard, for the issue stage of the RISC-V core. It provides NREAD combinational read ports and NWRITE synchronous write ports. Each register carries a saturating outstanding-write counter, so several in-flight producers may target the same register. A flush input squashes all reservations on pipeline redirect.

## Interface
- XLEN, 32, data width
- NREGS, 32, architectural registers including x0 (16 for RV32E)
- AW, $clog2(NREGS), register index width (derived)
- NREAD, 2, read ports
- NWRITE, 2, write ports; higher index = later pipeline stage
- CNT_W, 2, pending-counter width; maximum outstanding writes per register = 2^CNT_W-1
- clk  in  1  clock
- reset_n  in  1  reset, synchronous, active-low
- rs_idx  in  NREAD*AW  read indices, port p at [p*AW +: AW]
- rs_valid  out  NREAD  operand available
- rs_data  out  NREAD*XLEN  operand data
- rd  in  AW  destination to reserve
- reserve  in  1  reserve rd this cycle
- reserve_ready  out  1  reservation accepted (combinational)
- wreg  in  NWRITE*AW  write indices
- wdata  in  NWRITE*XLEN  write data
- wen  in  NWRITE  write enables
- flush  in  1  clear all reservations

## Operation
- x0:
  - reads return valid=1, data=0;
  - writes and reservations to x0 are ignored;
  - reserve_ready=1 for rd=0.
- cnt[r]: pending writes. Register r is clean when cnt[r]=0.
- Per cycle, for each r≠0:
  - w_r = number of enabled write ports with wreg=r.
  - cnt_next = sat0(cnt − w_r + (reserve accepted & rd=r)).
  - The counter floors at 0. A write without a reservation is legal and leaves cnt at 0.
- Reserve accepted when reserve & (rd=0 | cnt_post[rd] < max), where cnt_post = cnt − w_rd. A full counter that is being drained in the same cycle therefore accepts.
- reserve_ready = ~reserve | accepted. The issue stage stalls on ~reserve_ready.
- Multiple writes to the same register in one cycle: the highest port index supplies the data; every write decrements cnt.
- flush:
  - all cnt_next = 0;
  - reservations in the same cycle are dropped;
  - same-cycle writes still update data.
- Reads (combinational):
  - rs_valid = (idx=0) | (cnt[idx] − w_idx ≤ 0) (bypass build) or (cnt[idx]=0) (no-bypass build).
  - rs_data = highest-index matching write data (bypass build, when a write matches) else regs[idx].
- Reset: all regs = 0 and all cnt = 0, so every register reads valid=1, data=0. Reset overrides flush, reserve and wen in the same cycle.

## Timing
- Read: 0-cycle combinational path from rs_idx/wen/wreg/wdata to rs_valid/rs_data.
- Write: data visible through the array on the cycle after wen. With bypass, visible in the same cycle.
- Reservation: rd reads invalid from the cycle after the accepted reserve.
- Reserve and a write to the same register in the same cycle: cnt is unchanged (reserve +1, write −1). rs_valid follows the pre-update cnt/bypass rule.
- Counter at max, reserve, no draining write: reserve_ready=0 and cnt is unchanged.
- No output is registered. Outputs after reset: rs_valid=all 1, rs_data=0, reserve_ready=1.

## Configuration
- REGFILE_BYPASS_EN defined:
  - write-to-read passthrough as described;
  - a register whose last pending write lands this cycle reads valid with the new data.
- REGFILE_BYPASS_EN undefined:
  - reads see array contents and cnt state only;
  - a written value is visible, and valid asserts, one cycle after the write;
  - removes the wdata-to-rs_data path for timing.

## Structure
- The shared defines.vh include holds:
  - the ABI register name function;
  - RV32E/RV32I NREGS constants;
  - the flattened-port slice macros.
- Sub-module regfile_scoreboard:
  - owns the cnt array, the accept/flush logic, reserve_ready and the per-read "clean" outputs;
  - the data array and bypass muxes stay in the top module.
- Non-synthesis $display trace of reserve/write events, matching existing regfile trace format.

## Test plan
- Reset, then read x5 and x0 on both ports -> valid=1, data=0 on all. Write x0=0xDEAD then read x0 -> 0.
- Reserve x3 three times (CNT_W=2) -> reserve_ready=1 each time, x3 invalid. Fourth reserve -> reserve_ready=0, cnt stays 3. Three writes of 0x11,0x22,0x33 -> valid after the third, data 0x33.
- Ports 0 and 1 both write x7 (0xAAAA, 0xBBBB) with cnt=2 -> x7=0xBBBB, cnt=0, valid.
- Bypass build: x9 reserved, wen0 x9=0x1234 -> rs_valid=1, rs_data=0x1234 in the same cycle. No-bypass build: valid and data appear one cycle later.
- cnt[x4]=max, same cycle reserve x4 plus write x4 -> reserve_ready=1, cnt unchanged, x4 data updated.
- Reserve x2, x6, then flush with a concurrent reserve x8 and write x6=0x55 -> all valid next cycle, x6=0x55, x8 not reserved. Reset asserted mid-sequence -> all counters and data are 0.

Source files
------------

// File: rtl/regfile_sb_pkg.sv
// Shared definitions for the issue-stage register file and its scoreboard.
// Register counts for the two base ISAs and the reservation outcome type.
package regfile_sb_pkg;

    localparam int NREGS_RV32I = 32;
    localparam int NREGS_RV32E = 16;

    // Outcome of a reservation request in the current cycle
    typedef enum logic [1:0] {
        RSV_IDLE,
        RSV_ACCEPT,
        RSV_STALL,
        RSV_DROP
    } rsv_status_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one saturating outstanding-write counter per
// register, reservation accept/stall, flush, and per-read-port clean flags.
// REGFILE_BYPASS_EN: a register whose last pending write lands this cycle
// is reported clean in the same cycle.
module regfile_scoreboard
    import regfile_sb_pkg::*;
#(
    parameter int NREGS  = NREGS_RV32I,
    parameter int AW     = $clog2(NREGS),
    parameter int NREAD  = 2,
    parameter int NWRITE = 2,
    parameter int CNT_W  = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NREAD*AW-1:0]  rs_idx,
    input  logic [AW-1:0]        rd,
    input  logic                 reserve,
    input  logic [NWRITE*AW-1:0] wreg,
    input  logic [NWRITE-1:0]    wen,
    input  logic                 flush,
    output logic                 reserve_ready,
    output logic [NREAD-1:0]     rs_clean
);

    localparam int WC = $clog2(NWRITE + 1);
    localparam int SW = CNT_W + WC + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt      [NREGS];
    logic [CNT_W-1:0] cnt_next [NREGS];
    logic [WC-1:0]    wcount   [NREGS];
    logic [SW-1:0]    post_rd;
    rsv_status_e      rsv_status;

    // Count the enabled write ports landing on each register (x0 never counts)
    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            wcount[r] = '0;
            for (int p = 0; p < NWRITE; p++) begin
                if (wen[p] && wreg[p*AW +: AW] == AW'(r) && r != 0) begin
                    wcount[r] = wcount[r] + WC'(1);
                end
            end
        end
    end

    // Decide the reservation: stall only if rd stays full after this cycle's drains
    always_comb begin
        post_rd    = '0;
        rsv_status = RSV_IDLE;
        if (SW'(cnt[rd]) > SW'(wcount[rd])) begin
            post_rd = SW'(cnt[rd]) - SW'(wcount[rd]);
        end
        if (reserve) begin
            if (rd != '0 && post_rd >= SW'(CNT_MAX)) begin
                rsv_status = RSV_STALL;
            end else if (flush || rd == '0) begin
                rsv_status = RSV_DROP;
            end else begin
                rsv_status = RSV_ACCEPT;
            end
        end
        reserve_ready = (rsv_status != RSV_STALL);
    end

    // Next counter value: add the accepted reservation, subtract writes, floor at zero
    always_comb begin
        logic [SW-1:0] sum;
        sum = '0;
        for (int r = 0; r < NREGS; r++) begin
            cnt_next[r] = '0;
            if (!flush && r != 0) begin
                sum = SW'(cnt[r]);
                if (rsv_status == RSV_ACCEPT && rd == AW'(r)) begin
                    sum = sum + SW'(1);
                end
                if (sum > SW'(wcount[r])) begin
                    cnt_next[r] = CNT_W'(sum - SW'(wcount[r]));
                end
            end
        end
    end

    // Counter state register
    always_ff @(posedge clk) begin
        for (int r = 0; r < NREGS; r++) begin
            if (!reset_n) begin
                cnt[r] <= '0;
            end else begin
                cnt[r] <= cnt_next[r];
            end
        end
    end

    // Per-read-port clean flag
    always_comb begin
        logic [AW-1:0] idx;
        idx = '0;
        for (int p = 0; p < NREAD; p++) begin
            idx = rs_idx[p*AW +: AW];
`ifdef REGFILE_BYPASS_EN
            rs_clean[p] = (idx == '0) || (SW'(cnt[idx]) <= SW'(wcount[idx]));
`else
            rs_clean[p] = (idx == '0) || (cnt[idx] == '0);
`endif
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Integer register file with pending-write scoreboard for the issue stage.
// NREAD combinational read ports, NWRITE synchronous write ports; the
// highest-index write port wins on a same-register collision.
// REGFILE_BYPASS_EN: forward same-cycle write data to the read ports.
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int NREGS  = NREGS_RV32I,
    parameter int AW     = $clog2(NREGS),
    parameter int NREAD  = 2,
    parameter int NWRITE = 2,
    parameter int CNT_W  = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NREAD*AW-1:0]    rs_idx,
    output logic [NREAD-1:0]       rs_valid,
    output logic [NREAD*XLEN-1:0]  rs_data,
    input  logic [AW-1:0]          rd,
    input  logic                   reserve,
    output logic                   reserve_ready,
    input  logic [NWRITE*AW-1:0]   wreg,
    input  logic [NWRITE*XLEN-1:0] wdata,
    input  logic [NWRITE-1:0]      wen,
    input  logic                   flush
);

    logic [XLEN-1:0] regs [NREGS];
    logic [NREAD-1:0] rs_clean;

    regfile_scoreboard #(
        .NREGS  (NREGS),
        .AW     (AW),
        .NREAD  (NREAD),
        .NWRITE (NWRITE),
        .CNT_W  (CNT_W)
    ) u_scoreboard (
        .clk           (clk),
        .reset_n       (reset_n),
        .rs_idx        (rs_idx),
        .rd            (rd),
        .reserve       (reserve),
        .wreg          (wreg),
        .wen           (wen),
        .flush         (flush),
        .reserve_ready (reserve_ready),
        .rs_clean      (rs_clean)
    );

    // Data array update; later ports overwrite earlier ones, x0 is never written
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int r = 0; r < NREGS; r++) begin
                regs[r] <= '0;
            end
        end else begin
            for (int p = 0; p < NWRITE; p++) begin
                if (wen[p] && wreg[p*AW +: AW] != '0) begin
                    regs[wreg[p*AW +: AW]] <= wdata[p*XLEN +: XLEN];
                end
            end
        end
    end

    // Read muxes: array contents, optionally overridden by same-cycle write data
    always_comb begin
        logic [AW-1:0] idx;
        idx      = '0;
        rs_data  = '0;
        rs_valid = rs_clean;
        for (int p = 0; p < NREAD; p++) begin
            idx = rs_idx[p*AW +: AW];
            rs_data[p*XLEN +: XLEN] = regs[idx];
`ifdef REGFILE_BYPASS_EN
            for (int q = 0; q < NWRITE; q++) begin
                if (wen[q] && wreg[q*AW +: AW] == idx) begin
                    rs_data[p*XLEN +: XLEN] = wdata[q*XLEN +: XLEN];
                end
            end
`endif
            if (idx == '0) begin
                rs_data[p*XLEN +: XLEN] = '0;
            end
        end
    end

endmodule
